regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register and data port.
REQ-002 Parameter NREGS, default 16, architectural register count; address width AW = clog2(NREGS).
REQ-003 Parameter PC_IDX, default 15, index of the program-counter alias.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 ra1, ra2, ra3  in  AW each  read addresses (operand A, operand B, shift amount).
REQ-008 rd1, rd2, rd3  out  WIDTH each  read data.
REQ-009 r15  in  WIDTH  PC+8 value, returned for reads of PC_IDX.
REQ-010 wea, waa, wda  in  1/AW/WIDTH  write port A (ALU writeback).
REQ-011 web, wab, wdb  in  1/AW/WIDTH  write port B (load writeback); clears the pending bit.
REQ-012 iss_v, iss_rd  in  1/AW  load issue; marks iss_rd pending.
REQ-013 stall  out  1  a read port addresses a pending register.
REQ-014 wcoll  out  1  registered flag: ports A and B wrote the same address in the last cycle.

Function
REQ-015 Storage: NREGS-1 registers of WIDTH bits; no storage at PC_IDX.
REQ-016 Reads combinational: rdN = r15 if raN==PC_IDX; otherwise register contents.
REQ-017 Write-through bypass: if raN matches an enabled write address this cycle, rdN returns that write data; port A data has priority over port B.
REQ-018 Writes take effect at the rising clk edge; wea/web addressing PC_IDX are ignored (no state change, no bypass).
REQ-019 Same-address collision (wea & web & waa==wab, not PC_IDX): port A data is stored, pending bit cleared, wcoll=1 for one cycle.
REQ-020 Pending vector pend[NREGS-1:0]: set at iss_rd on the edge when iss_v=1; cleared at wab on the edge when web=1.
REQ-021 Simultaneous iss_v and web on the same address: set wins (new load in flight).
REQ-022 iss_v with iss_rd==PC_IDX: ignored, pend[PC_IDX] stays 0.
REQ-023 stall = OR over N of (pend[raN] & ~(web & wab==raN)); a same-cycle port B writeback to the address suppresses stall.
REQ-024 Port A writes do not alter pend.
REQ-025 Address values >= NREGS: read returns 0, write/issue ignored.

Reset
REQ-026 reset asserted: all registers 0, pend all 0, wcoll 0, immediately and independent of clk.
REQ-027 Writes or issues presented while reset is asserted have no effect; first effective edge follows deassertion.
REQ-028 Outputs after reset: rd1..rd3 = 0 (or r15 for PC_IDX), stall 0, wcoll 0.

Structure
REQ-029 Shared package holds default WIDTH/NREGS/PC_IDX constants and the register-address typedef.
REQ-030 One sub-module, regfile_sb_score, owns pend and computes stall; storage and bypass live in the top.

Verification
REQ-031 Reset, then read r0..r14 -> all 0; ra1=15 with r15=0x00000108 -> rd1=0x00000108.
REQ-032 wea=1, waa=3, wda=0xDEADBEEF, ra2=3 same cycle -> rd2=0xDEADBEEF combinationally; retained next cycle.
REQ-033 wea & web to r5 with wda=0x11, wdb=0x22 -> r5=0x11 after edge, wcoll=1 for exactly one cycle.
REQ-034 iss_v, iss_rd=7; next cycle ra1=7 -> stall=1; web, wab=7, wdb=0x55 -> stall=0 that cycle, rd1=0x55, pend[7]=0 after edge.
REQ-035 wea=1, waa=15, wda=0x1234 -> no state change; ra3=15 returns r15, not 0x1234.
REQ-036 reset pulsed mid-cycle with pend[2]=1 and r2=0xA5 -> pend and r2 clear immediately, stall=0 before next edge.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and address type for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int NREGS_DEF  = 16;
    localparam int PC_IDX_DEF = 15;
    localparam int AW_DEF     = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_score.sv
// Load scoreboard: one pending bit per register, and the read-port stall built from it.
module regfile_sb_score
    import regfile_sb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int AW     = $clog2(NREGS)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_rd,
    input  logic          web,
    input  logic [AW-1:0] wab,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic          stall
);

    localparam int NSLOT = 1 << AW;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [NSLOT-1:0] pend_pad;

    // Clear first so a same-edge issue to the written register keeps the newer load pending.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            if (i != PC_IDX) begin
                if (web && wab == AW'(i))
                    pend_d[i] = 1'b0;
                if (iss_v && iss_rd == AW'(i))
                    pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    always_comb begin
        pend_pad = '0;
        pend_pad[NREGS-1:0] = pend_q;
    end

    always_comb begin
        stall = 1'b0;
        if (pend_pad[ra1] && !(web && wab == ra1)) stall = 1'b1;
        if (pend_pad[ra2] && !(web && wab == ra2)) stall = 1'b1;
        if (pend_pad[ra3] && !(web && wab == ra3)) stall = 1'b1;
    end

endmodule

// File: rtl/regfile_sb.sv
// Three-read, two-write register file with PC alias, write-through bypass and load scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int PC_IDX = PC_IDX_DEF,
    localparam int AW    = $clog2(NREGS)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    ra3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] rd3,
    input  logic [WIDTH-1:0] r15,
    input  logic             wea,
    input  logic [AW-1:0]    waa,
    input  logic [WIDTH-1:0] wda,
    input  logic             web,
    input  logic [AW-1:0]    wab,
    input  logic [WIDTH-1:0] wdb,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_rd,
    output logic             stall,
    output logic             wcoll
);

    localparam int            NSLOT = 1 << AW;
    localparam logic [AW-1:0] PC_A  = AW'(PC_IDX);

    logic [NSLOT-1:0] wr_ok;
    logic [WIDTH-1:0] rf_val [NSLOT];

    // Slots past NREGS and the PC alias get no flops; they read as 0 and swallow writes.
    for (genvar g = 0; g < NSLOT; g++) begin : g_reg
        if (g < NREGS && g != PC_IDX) begin : g_store
            logic [WIDTH-1:0] q_q, q_d;
            always_comb begin
                q_d = q_q;
                if (wea && waa == AW'(g))
                    q_d = wda;
                else if (web && wab == AW'(g))
                    q_d = wdb;
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    q_q <= '0;
                else
                    q_q <= q_d;
            end
            assign rf_val[g] = q_q;
            assign wr_ok[g]  = 1'b1;
        end else begin : g_none
            assign rf_val[g] = '0;
            assign wr_ok[g]  = 1'b0;
        end
    end

    logic [AW-1:0]    ra_a [3];
    logic [WIDTH-1:0] rd_a [3];

    assign ra_a[0] = ra1;
    assign ra_a[1] = ra2;
    assign ra_a[2] = ra3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_a[p] = '0;
            if (ra_a[p] == PC_A)
                rd_a[p] = r15;
            else if (!wr_ok[ra_a[p]])
                rd_a[p] = '0;
            else if (wea && waa == ra_a[p])
                rd_a[p] = wda;
            else if (web && wab == ra_a[p])
                rd_a[p] = wdb;
            else
                rd_a[p] = rf_val[ra_a[p]];
        end
    end

    assign rd1 = rd_a[0];
    assign rd2 = rd_a[1];
    assign rd3 = rd_a[2];

    logic wcoll_q, wcoll_d;

    assign wcoll_d = wea && web && (waa == wab) && wr_ok[waa];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wcoll_q <= 1'b0;
        else
            wcoll_q <= wcoll_d;
    end

    assign wcoll = wcoll_q;

    regfile_sb_score #(
        .NREGS  (NREGS),
        .PC_IDX (PC_IDX),
        .AW     (AW)
    ) u_score (
        .clk    (clk),
        .reset  (reset),
        .iss_v  (iss_v),
        .iss_rd (iss_rd),
        .web    (web),
        .wab    (wab),
        .ra1    (ra1),
        .ra2    (ra2),
        .ra3    (ra3),
        .stall  (stall)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: per-cycle vector table through a scoreboard, plus reset corners.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    reg_addr_t   ra1, ra2, ra3, waa, wab, iss_rd;
    logic [31:0] rd1, rd2, rd3, r15, wda, wdb;
    logic        wea, web, iss_v, stall, wcoll;

    int total = 0;
    int bad   = 0;

    regfile_sb dut (
        .clk    (clk),
        .reset  (reset),
        .ra1    (ra1),
        .ra2    (ra2),
        .ra3    (ra3),
        .rd1    (rd1),
        .rd2    (rd2),
        .rd3    (rd3),
        .r15    (r15),
        .wea    (wea),
        .waa    (waa),
        .wda    (wda),
        .web    (web),
        .wab    (wab),
        .wdb    (wdb),
        .iss_v  (iss_v),
        .iss_rd (iss_rd),
        .stall  (stall),
        .wcoll  (wcoll)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wea;
        reg_addr_t   waa;
        logic [31:0] wda;
        logic        web;
        reg_addr_t   wab;
        logic [31:0] wdb;
        logic        iss_v;
        reg_addr_t   iss_rd;
        reg_addr_t   ra1, ra2, ra3;
        logic [31:0] r15;
        logic [31:0] e1, e2, e3;
        logic        es, ew;
    } vec_t;

    typedef struct {
        logic [31:0] rd1, rd2, rd3;
        logic        st, wc;
    } exp_t;

    localparam int NV = 27;
    vec_t tbl [NV];
    exp_t exp_q [$];

    function automatic vec_t mk(
        input logic [31:0] a_wea, a_waa, a_wda, a_web, a_wab, a_wdb, a_iv, a_ird,
        input logic [31:0] a_r1, a_r2, a_r3, a_r15, a_e1, a_e2, a_e3, a_es, a_ew);
        vec_t v;
        v.wea = a_wea[0];   v.waa = reg_addr_t'(a_waa); v.wda = a_wda;
        v.web = a_web[0];   v.wab = reg_addr_t'(a_wab); v.wdb = a_wdb;
        v.iss_v = a_iv[0];  v.iss_rd = reg_addr_t'(a_ird);
        v.ra1 = reg_addr_t'(a_r1); v.ra2 = reg_addr_t'(a_r2); v.ra3 = reg_addr_t'(a_r3);
        v.r15 = a_r15; v.e1 = a_e1; v.e2 = a_e2; v.e3 = a_e3;
        v.es = a_es[0]; v.ew = a_ew[0];
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, idx, got, want);
        end
    endtask

    task automatic idle();
        wea = 1'b0; waa = '0; wda = '0;
        web = 1'b0; wab = '0; wdb = '0;
        iss_v = 1'b0; iss_rd = '0;
        ra1 = '0; ra2 = '0; ra3 = '0;
        r15 = 32'h0000_0108;
    endtask

    task automatic run_vec(input int idx);
        exp_t e;
        @(negedge clk);
        wea = tbl[idx].wea; waa = tbl[idx].waa; wda = tbl[idx].wda;
        web = tbl[idx].web; wab = tbl[idx].wab; wdb = tbl[idx].wdb;
        iss_v = tbl[idx].iss_v; iss_rd = tbl[idx].iss_rd;
        ra1 = tbl[idx].ra1; ra2 = tbl[idx].ra2; ra3 = tbl[idx].ra3;
        r15 = tbl[idx].r15;
        e.rd1 = tbl[idx].e1; e.rd2 = tbl[idx].e2; e.rd3 = tbl[idx].e3;
        e.st = tbl[idx].es; e.wc = tbl[idx].ew;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        cmp("rd1",   idx, rd1, e.rd1);
        cmp("rd2",   idx, rd2, e.rd2);
        cmp("rd3",   idx, rd3, e.rd3);
        cmp("stall", idx, {31'b0, stall}, {31'b0, e.st});
        cmp("wcoll", idx, {31'b0, wcoll}, {31'b0, e.wc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        //              wea waa wda           web wab wdb        iv ird r1  r2  r3  r15           e1            e2            e3            es ew
        tbl[0]  = mk(1,  3, 32'hDEADBEEF, 0,  0, 0,         0, 0, 15, 3,  4,  32'h108, 32'h108,      32'hDEADBEEF, 0,            0, 0);
        tbl[1]  = mk(0,  0, 0,            0,  0, 0,         0, 0, 0,  3,  15, 32'h108, 0,            32'hDEADBEEF, 32'h108,      0, 0);
        tbl[2]  = mk(1,  5, 32'h11,       1,  5, 32'h22,    0, 0, 5,  3,  0,  32'h108, 32'h11,       32'hDEADBEEF, 0,            0, 0);
        tbl[3]  = mk(0,  0, 0,            0,  0, 0,         0, 0, 5,  0,  0,  32'h108, 32'h11,       0,            0,            0, 1);
        tbl[4]  = mk(0,  0, 0,            0,  0, 0,         0, 0, 5,  0,  0,  32'h108, 32'h11,       0,            0,            0, 0);
        tbl[5]  = mk(1,  8, 32'h88,       1,  6, 32'h66,    0, 0, 6,  8,  5,  32'h108, 32'h66,       32'h88,       32'h11,       0, 0);
        tbl[6]  = mk(0,  0, 0,            0,  0, 0,         1, 7, 6,  8,  7,  32'h108, 32'h66,       32'h88,       0,            0, 0);
        tbl[7]  = mk(0,  0, 0,            0,  0, 0,         0, 0, 7,  0,  0,  32'h108, 0,            0,            0,            1, 0);
        tbl[8]  = mk(0,  0, 0,            1,  7, 32'h55,    0, 0, 7,  0,  0,  32'h108, 32'h55,       0,            0,            0, 0);
        tbl[9]  = mk(0,  0, 0,            0,  0, 0,         0, 0, 7,  0,  0,  32'h108, 32'h55,       0,            0,            0, 0);
        tbl[10] = mk(1, 15, 32'h1234,     0,  0, 0,         0, 0, 15, 0,  15, 32'h108, 32'h108,      0,            32'h108,      0, 0);
        tbl[11] = mk(0,  0, 0,            0,  0, 0,         0, 0, 0,  3,  15, 32'h200, 0,            32'hDEADBEEF, 32'h200,      0, 0);
        tbl[12] = mk(1, 15, 32'h1,        1, 15, 32'h2,     1, 15, 15, 0, 0,  32'h108, 32'h108,      0,            0,            0, 0);
        tbl[13] = mk(0,  0, 0,            0,  0, 0,         0, 0, 15, 15, 15, 32'h108, 32'h108,      32'h108,      32'h108,      0, 0);
        tbl[14] = mk(0,  0, 0,            1,  9, 32'h99,    1, 9, 9,  0,  0,  32'h108, 32'h99,       0,            0,            0, 0);
        tbl[15] = mk(0,  0, 0,            0,  0, 0,         0, 0, 9,  0,  0,  32'h108, 32'h99,       0,            0,            1, 0);
        tbl[16] = mk(0,  0, 0,            1,  9, 32'h9A,    0, 0, 0,  9,  0,  32'h108, 0,            32'h9A,       0,            0, 0);
        tbl[17] = mk(0,  0, 0,            0,  0, 0,         1, 10, 9, 0,  0,  32'h108, 32'h9A,       0,            0,            0, 0);
        tbl[18] = mk(0,  0, 0,            0,  0, 0,         0, 0, 0,  0,  10, 32'h108, 0,            0,            0,            1, 0);
        tbl[19] = mk(1, 10, 32'hAA,       0,  0, 0,         0, 0, 0,  0,  10, 32'h108, 0,            0,            32'hAA,       1, 0);
        tbl[20] = mk(0,  0, 0,            0,  0, 0,         0, 0, 0,  10, 0,  32'h108, 0,            32'hAA,       0,            1, 0);
        tbl[21] = mk(1, 10, 32'hCC,       1, 10, 32'hBB,    0, 0, 0,  10, 0,  32'h108, 0,            32'hCC,       0,            0, 0);
        tbl[22] = mk(0,  0, 0,            0,  0, 0,         0, 0, 0,  10, 3,  32'h108, 0,            32'hCC,       32'hDEADBEEF, 0, 1);
        tbl[23] = mk(0,  0, 0,            0,  0, 0,         1, 12, 0, 0,  0,  32'h108, 0,            0,            0,            0, 0);
        tbl[24] = mk(0,  0, 0,            1, 11, 32'h77,    0, 0, 12, 11, 0,  32'h108, 0,            32'h77,       0,            1, 0);
        tbl[25] = mk(0,  0, 0,            1, 12, 32'h1200,  0, 0, 12, 11, 0,  32'h108, 32'h1200,     32'h77,       0,            0, 0);
        tbl[26] = mk(0,  0, 0,            0,  0, 0,         0, 0, 12, 11, 14, 32'h108, 32'h1200,     32'h77,       0,            0, 0);

        reset = 1'b1;
        idle();
        ra1 = 4'd0; ra2 = 4'd1; ra3 = 4'd15;
        #1;
        cmp("rst_rd1",   -1, rd1, 32'h0);
        cmp("rst_rd2",   -1, rd2, 32'h0);
        cmp("rst_rd3",   -1, rd3, 32'h108);
        cmp("rst_stall", -1, {31'b0, stall}, 32'h0);
        cmp("rst_wcoll", -1, {31'b0, wcoll}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        idle();
        for (int i = 0; i < 15; i++) begin
            ra1 = reg_addr_t'(i);
            #1;
            cmp("init_read", i, rd1, 32'h0);
        end
        ra1 = 4'd15;
        #1;
        cmp("pc_read", 15, rd1, 32'h108);

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // Mid-cycle reset clears pending state and storage without waiting for an edge.
        @(negedge clk);
        idle();
        wea = 1'b1; waa = 4'd2; wda = 32'hA5;
        iss_v = 1'b1; iss_rd = 4'd2;
        @(negedge clk);
        idle();
        ra1 = 4'd2;
        #1;
        cmp("pre_rst_rd1",   100, rd1, 32'hA5);
        cmp("pre_rst_stall", 100, {31'b0, stall}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        cmp("async_rst_rd1",   101, rd1, 32'h0);
        cmp("async_rst_stall", 101, {31'b0, stall}, 32'h0);
        cmp("async_rst_wcoll", 101, {31'b0, wcoll}, 32'h0);

        // Traffic presented while reset is held must be discarded.
        wea = 1'b1; waa = 4'd4; wda = 32'h44;
        web = 1'b1; wab = 4'd4; wdb = 32'h45;
        iss_v = 1'b1; iss_rd = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        cmp("held_wcoll", 102, {31'b0, wcoll}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        ra1 = 4'd4; ra2 = 4'd2;
        #1;
        cmp("post_rst_rd1",   103, rd1, 32'h0);
        cmp("post_rst_rd2",   103, rd2, 32'h0);
        cmp("post_rst_stall", 103, {31'b0, stall}, 32'h0);
        @(negedge clk);
        #1;
        cmp("post_rst_stall2", 104, {31'b0, stall}, 32'h0);
        cmp("post_rst_wcoll",  104, {31'b0, wcoll}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
